// File: rtl/fetch_stage.sv
// Instruction fetch front end: one request in flight, one-entry pending buffer behind the decode register.
// Optional misaligned-redirect fault detection is enabled by defining FETCH_MISALIGN_CHECK_EN.
//
// state  | meaning
// IDLE   | no request; after reset, while the pending buffer drains, or parked on a fault
// REQ    | imem_req_valid high, presenting pc
// WAIT   | one request accepted, its response is awaited
// DROP   | a request is in flight whose response must be discarded after a redirect

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;

  logic        accept;
  logic        resp_take;
  logic        in_flight_after;
  logic        redir_bad;
  logic        fault_hold;
  logic [31:0] redir_pc;

  assign accept    = (state_q == S_REQ) && imem_req_ready;
  assign resp_take = (state_q == S_WAIT) && imem_resp_valid;
  // A request is still owed a response after this edge if one is accepted now or one is pending and not answered now.
  assign in_flight_after = accept ||
                           (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_resp_valid);
  assign redir_pc  = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign redir_bad  = |redirect_pc[1:0];
  assign fault_hold = fault_q;

  always_comb begin
    fault_d = fault_q;
    if (redirect_en) fault_d = redir_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  assign fetch_fault = fault_q;
`else
  assign redir_bad   = 1'b0;
  assign fault_hold  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    pend_data_d   = pend_data_q;
    pend_pc_d     = pend_pc_q;
    pend_valid_d  = pend_valid_q;

    if (redirect_en) begin
      pc_d          = redir_pc;
      instr_valid_d = 1'b0;
      pend_valid_d  = 1'b0;
      if (redir_bad)            state_d = S_IDLE;
      else if (in_flight_after) state_d = S_DROP;
      else                      state_d = S_REQ;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;

      // pc has already advanced past the outstanding request, so its address is pc - 4.
      if (resp_take) begin
        if (!instr_valid_q || !stall) begin
          instr_d       = imem_resp_data;
          instr_pc_d    = pc_q - 32'd4;
          instr_valid_d = 1'b1;
        end else begin
          pend_data_d  = imem_resp_data;
          pend_pc_d    = pc_q - 32'd4;
          pend_valid_d = 1'b1;
        end
      end else if (!stall) begin
        if (pend_valid_q) begin
          instr_d       = pend_data_q;
          instr_pc_d    = pend_pc_q;
          instr_valid_d = 1'b1;
          pend_valid_d  = 1'b0;
        end else begin
          instr_valid_d = 1'b0;
        end
      end

      case (state_q)
        S_IDLE:  if (!fault_hold && !pend_valid_d) state_d = S_REQ;
        S_REQ:   if (accept) state_d = S_WAIT;
        S_WAIT:  if (imem_resp_valid) state_d = pend_valid_d ? S_IDLE : S_REQ;
        S_DROP:  if (imem_resp_valid) state_d = pend_valid_d ? S_IDLE : S_REQ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      instr_pc_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      pend_data_q   <= 32'h0000_0000;
      pend_pc_q     <= 32'h0000_0000;
      pend_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      pend_data_q   <= pend_data_d;
      pend_pc_q     <= pend_pc_d;
      pend_valid_q  <= pend_valid_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_valid    = instr_valid_q;

endmodule
